// File: rtl/corr_epoch_sched_if.sv
// Readout handshake between the epoch scheduler and the shared readout mover.
//   rd_req : scheduler -> mover, a channel is waiting to be copied
//   rd_ch  : scheduler -> mover, channel index, stable while rd_req=1
//   rd_ack : mover -> scheduler, rd_ch has been copied (meaningful only while rd_req=1)
// The scheduler uses the master modport and the mover uses the slave modport.
interface corr_epoch_sched_if #(
  parameter int CH_W = 4
);
  logic            rd_req;
  logic [CH_W-1:0] rd_ch;
  logic            rd_ack;

  modport master (output rd_req, output rd_ch, input rd_ack);
  modport slave  (input rd_req, input rd_ch, output rd_ack);
endinterface

// File: rtl/corr_epoch_sched.sv
// Round-robin readout scheduler for a bank of correlator channels.
// Channels raise a one-cycle epoch pulse when fresh IQ data is latched. Each pulse
// becomes a pending request. Requests are granted one at a time to a shared
// readout mover over the rd handshake interface. Completed readouts are counted
// and coalesced into an interrupt pulse, raised on a count threshold or on a
// timeout. Sticky per-channel overrun flags record epochs that arrive before the
// previous data has been read out.
// Ports:
//   clk, resetn   : clock, asynchronous active-low reset
//   epoch_pulse   : per-channel new-data pulse
//   ch_en         : per-channel enable, disabled channels never become pending
//   rd            : readout handshake (master side: rd_req, rd_ch out, rd_ack in)
//   irq_thr       : completions per interrupt, 0 disables the threshold trigger
//   irq_tmo       : cycles after the first unreported completion, 0 disables the timeout
//   irq_pulse     : one-cycle coalesced interrupt
//   done_cnt      : completions since the last irq_pulse (saturating)
//   overrun       : sticky per-channel overrun flags
//   ovr_clr       : per-channel clear of overrun (a simultaneous set wins)
//   busy          : a request is outstanding or any channel is pending (one cycle lag)
module corr_epoch_sched #(
  parameter int N_CH  = 16,
  parameter int CH_W  = $clog2(N_CH),
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [N_CH-1:0]     epoch_pulse,
  input  logic [N_CH-1:0]     ch_en,
  corr_epoch_sched_if.master  rd,
  input  logic [CNT_W-1:0]    irq_thr,
  input  logic [CNT_W-1:0]    irq_tmo,
  output logic                irq_pulse,
  output logic [CNT_W-1:0]    done_cnt,
  output logic [N_CH-1:0]     overrun,
  input  logic [N_CH-1:0]     ovr_clr,
  output logic                busy
);

  typedef enum logic {S_IDLE, S_REQ} state_t;

  localparam logic [N_CH-1:0]  ONE_HOT0 = N_CH'(1);
  localparam logic [CH_W:0]    N_CH_W   = (CH_W+1)'(N_CH);
  localparam logic [CH_W-1:0]  LAST_RST = CH_W'(N_CH - 1);

  state_t          state_reg;
  logic [N_CH-1:0] pending_reg;
  logic [CH_W-1:0] last_reg;
  logic [CNT_W-1:0] done_cnt_reg;
  logic [CNT_W-1:0] timer_reg;
  logic [N_CH-1:0] overrun_reg;
  logic            irq_pulse_reg;
  logic            busy_reg;

  logic            ack;
  logic [N_CH-1:0] pulse_en;
  logic [CH_W-1:0] base_ch;
  logic            pick_valid;
  logic [CH_W-1:0] pick_idx;
  logic            grant;
  logic [N_CH-1:0] grant_mask;
  logic [N_CH-1:0] ovr_set;
  logic [N_CH-1:0] pending_next;
  logic [N_CH-1:0] overrun_next;
  logic            fire;

  // An acknowledge only counts while a request is actually outstanding.
  assign ack      = rd.rd_req & rd.rd_ack;
  assign pulse_en = epoch_pulse & ch_en;

  // The round-robin search starts after the channel just completed when granting
  // back-to-back, otherwise after the last completed channel.
  assign base_ch = (state_reg == S_REQ) ? rd.rd_ch : last_reg;

  // Scan offsets from N_CH down to 1 so the smallest offset is the last to win.
  always_comb begin
    logic [CH_W:0] sum;
    pick_valid = 1'b0;
    pick_idx   = '0;
    sum        = '0;
    for (int k = N_CH; k >= 1; k--) begin
      sum = {1'b0, base_ch} + (CH_W+1)'(k);
      if (sum >= N_CH_W) begin
        sum = sum - N_CH_W;
      end
      if (pending_reg[sum[CH_W-1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = sum[CH_W-1:0];
      end
    end
  end

  assign grant      = pick_valid & ((state_reg == S_IDLE) | ack);
  assign grant_mask = grant ? (ONE_HOT0 << pick_idx) : '0;

  // A new epoch overruns if the channel is still waiting, or if its data is being
  // read right now and the mover has not finished copying it.
  assign ovr_set = pulse_en & (pending_reg |
                   ((rd.rd_req & ~rd.rd_ack) ? (ONE_HOT0 << rd.rd_ch) : '0));

  // A fresh epoch on the channel being granted keeps it pending.
  assign pending_next = ((pending_reg & ~grant_mask) | pulse_en) & ch_en;
  assign overrun_next = (overrun_reg & ~ovr_clr) | ovr_set;

  // Compare against the registered counters; >= so a threshold lowered below the
  // current count still fires on the next cycle.
  assign fire = ((irq_thr != '0) && (done_cnt_reg >= irq_thr)) ||
                ((irq_tmo != '0) && (timer_reg >= irq_tmo));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg     <= S_IDLE;
      rd.rd_req     <= 1'b0;
      rd.rd_ch      <= '0;
      last_reg      <= LAST_RST;
      pending_reg   <= '0;
      overrun_reg   <= '0;
      done_cnt_reg  <= '0;
      timer_reg     <= '0;
      irq_pulse_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      pending_reg <= pending_next;
      overrun_reg <= overrun_next;
      busy_reg    <= rd.rd_req | (|pending_reg);

      case (state_reg)
        S_IDLE: begin
          if (pick_valid) begin
            rd.rd_ch  <= pick_idx;
            rd.rd_req <= 1'b1;
            state_reg <= S_REQ;
          end
        end
        S_REQ: begin
          if (ack) begin
            last_reg <= rd.rd_ch;
            if (pick_valid) begin
              rd.rd_ch <= pick_idx;
            end else begin
              rd.rd_req <= 1'b0;
              state_reg <= S_IDLE;
            end
          end
        end
        default: state_reg <= S_IDLE;
      endcase

      irq_pulse_reg <= fire;
      if (fire) begin
        // A completion in the interrupt cycle belongs to the next batch.
        done_cnt_reg <= ack ? CNT_W'(1) : '0;
        timer_reg    <= '0;
      end else begin
        if (ack && !(&done_cnt_reg)) begin
          done_cnt_reg <= done_cnt_reg + 1'b1;
        end
        if ((done_cnt_reg != '0) && !(&timer_reg)) begin
          timer_reg <= timer_reg + 1'b1;
        end
      end
    end
  end

  assign irq_pulse = irq_pulse_reg;
  assign done_cnt  = done_cnt_reg;
  assign overrun   = overrun_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_corr_epoch_sched.sv
module tb_corr_epoch_sched;
  localparam int N_CH  = 16;
  localparam int CH_W  = 4;
  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic [N_CH-1:0]  epoch_pulse = '0;
  logic [N_CH-1:0]  ch_en = '1;
  logic [CNT_W-1:0] irq_thr = '0;
  logic [CNT_W-1:0] irq_tmo = '0;
  logic             irq_pulse;
  logic [CNT_W-1:0] done_cnt;
  logic [N_CH-1:0]  overrun;
  logic [N_CH-1:0]  ovr_clr = '0;
  logic             busy;

  corr_epoch_sched_if #(.CH_W(CH_W)) rd_if ();

  corr_epoch_sched #(.N_CH(N_CH), .CH_W(CH_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetn(resetn), .epoch_pulse(epoch_pulse), .ch_en(ch_en),
    .rd(rd_if), .irq_thr(irq_thr), .irq_tmo(irq_tmo), .irq_pulse(irq_pulse),
    .done_cnt(done_cnt), .overrun(overrun), .ovr_clr(ovr_clr), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;

  // Behavioural reference: pending set, current grant, coalescing counters.
  bit               m_req;
  int               m_ch;
  int               m_last;
  logic [N_CH-1:0]  m_pend;
  logic [N_CH-1:0]  m_ovr;
  logic [CNT_W-1:0] m_done;
  logic [CNT_W-1:0] m_timer;
  bit               m_irq;
  bit               m_busy;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_req = 0; m_ch = 0; m_last = N_CH - 1; m_pend = '0; m_ovr = '0;
    m_done = '0; m_timer = '0; m_irq = 0; m_busy = 0;
  endtask

  task automatic model_step();
    logic [N_CH-1:0] set_v;
    logic [N_CH-1:0] pend;
    bit acc, fire;
    int base, found, c;
    acc   = m_req && rd_if.rd_ack;
    fire  = (irq_thr != 0 && m_done >= irq_thr) || (irq_tmo != 0 && m_timer >= irq_tmo);
    set_v = epoch_pulse & ch_en;
    m_busy = m_req || (m_pend != 0);
    for (int i = 0; i < N_CH; i++) begin
      if (set_v[i] && (m_pend[i] || (m_req && m_ch == i && !rd_if.rd_ack))) m_ovr[i] = 1'b1;
      else if (ovr_clr[i]) m_ovr[i] = 1'b0;
    end
    pend = m_pend;
    if (!m_req || acc) begin
      base = m_req ? m_ch : m_last;
      if (acc) m_last = m_ch;
      found = -1;
      for (int k = 1; k <= N_CH; k++) begin
        c = (base + k) % N_CH;
        if (found < 0 && pend[c]) found = c;
      end
      if (found >= 0) begin
        m_req = 1; m_ch = found; pend[found] = 1'b0;
      end else begin
        m_req = 0;
      end
    end
    m_pend = (pend | set_v) & ch_en;
    m_irq = fire;
    if (fire) begin
      m_done = acc ? 1 : 0;
      m_timer = 0;
    end else begin
      if (m_done != 0 && m_timer != CMAX) m_timer = m_timer + 1;
      if (acc && m_done != CMAX) m_done = m_done + 1;
    end
  endtask

  task automatic compare_all();
    chk("rd_req", 64'(rd_if.rd_req), 64'(m_req));
    if (m_req) chk("rd_ch", 64'(rd_if.rd_ch), 64'(m_ch));
    chk("done_cnt", 64'(done_cnt), 64'(m_done));
    chk("overrun", 64'(overrun), 64'(m_ovr));
    chk("irq_pulse", 64'(irq_pulse), 64'(m_irq));
    chk("busy", 64'(busy), 64'(m_busy));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    compare_all();
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_rd_req"}, 64'(rd_if.rd_req), 64'd0);
    chk({tag, "_rd_ch"}, 64'(rd_if.rd_ch), 64'd0);
    chk({tag, "_irq"}, 64'(irq_pulse), 64'd0);
    chk({tag, "_done"}, 64'(done_cnt), 64'd0);
    chk({tag, "_ovr"}, 64'(overrun), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int t0, a, irq_seen, irq_at;
    rd_if.rd_ack = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_values("reset");
    resetn = 1'b1;

    // Single channel: pulse at t, grant at t+2, ack at t+6, idle at t+7.
    tick();
    t0 = cyc;
    epoch_pulse = 16'h0008; tick(); epoch_pulse = '0;
    chk("single_pending_no_req", 64'(rd_if.rd_req), 64'd0);
    tick();
    chk("single_req_t2", 64'(rd_if.rd_req), 64'd1);
    chk("single_ch3", 64'(rd_if.rd_ch), 64'd3);
    chk("single_req_cycle", 64'(cyc - t0), 64'd2);
    repeat (4) tick();
    rd_if.rd_ack = 1'b1; tick(); rd_if.rd_ack = 1'b0;
    chk("single_req_drop_t7", 64'(rd_if.rd_req), 64'd0);
    chk("single_drop_cycle", 64'(cyc - t0), 64'd7);
    chk("single_done1", 64'(done_cnt), 64'd1);
    tick();

    // Round robin: make 5 the last grant, then 1,5,9 together -> 9,1,5.
    epoch_pulse = 16'h0020; tick(); epoch_pulse = '0;
    tick();
    rd_if.rd_ack = 1'b1; tick(); rd_if.rd_ack = 1'b0;
    epoch_pulse = 16'h0222; tick(); epoch_pulse = '0;
    rd_if.rd_ack = 1'b1;
    tick(); chk("rr_first_9", 64'(rd_if.rd_ch), 64'd9);
    tick(); chk("rr_second_1", 64'(rd_if.rd_ch), 64'd1);
    chk("rr_no_gap", 64'(rd_if.rd_req), 64'd1);
    tick(); chk("rr_third_5", 64'(rd_if.rd_ch), 64'd5);
    tick(); chk("rr_done_idle", 64'(rd_if.rd_req), 64'd0);
    rd_if.rd_ack = 1'b0;
    tick();

    // Overrun case 1: mover stalled on channel 0 while channel 2 pulses twice.
    epoch_pulse = 16'h0001; tick(); epoch_pulse = '0;
    tick();
    epoch_pulse = 16'h0004; tick(); epoch_pulse = '0;
    tick();
    chk("ovr1_not_yet", 64'(overrun[2]), 64'd0);
    epoch_pulse = 16'h0004; tick(); epoch_pulse = '0;
    chk("ovr1_set", 64'(overrun[2]), 64'd1);
    rd_if.rd_ack = 1'b1;
    tick(); chk("ovr1_grant2", 64'(rd_if.rd_ch), 64'd2);
    tick(); chk("ovr1_one_grant", 64'(rd_if.rd_req), 64'd0);
    rd_if.rd_ack = 1'b0;
    tick();
    ovr_clr = 16'h0004; tick(); ovr_clr = '0;
    chk("ovr_clr", 64'(overrun[2]), 64'd0);

    // Overrun case 2: pulse during its own request -> second grant after ack.
    epoch_pulse = 16'h0004; tick(); epoch_pulse = '0;
    tick();
    chk("ovr2_req_ch2", 64'(rd_if.rd_ch), 64'd2);
    epoch_pulse = 16'h0004; tick(); epoch_pulse = '0;
    chk("ovr2_set", 64'(overrun[2]), 64'd1);
    rd_if.rd_ack = 1'b1;
    tick();
    chk("ovr2_second_req", 64'(rd_if.rd_req), 64'd1);
    chk("ovr2_second_ch", 64'(rd_if.rd_ch), 64'd2);
    tick();
    chk("ovr2_idle", 64'(rd_if.rd_req), 64'd0);
    rd_if.rd_ack = 1'b0;
    ovr_clr = 16'h0004; tick(); ovr_clr = '0;

    // Threshold below current count fires on the next cycle.
    irq_thr = 16'd4;
    tick();
    chk("thr_low_fires", 64'(irq_pulse), 64'd1);
    chk("thr_low_clears", 64'(done_cnt), 64'd0);
    tick();

    // Threshold 4 with four back-to-back readouts.
    epoch_pulse = 16'h000F; tick(); epoch_pulse = '0;
    rd_if.rd_ack = 1'b1;
    tick();
    repeat (3) tick();
    tick(); rd_if.rd_ack = 1'b0;
    chk("thr_done4", 64'(done_cnt), 64'd4);
    chk("thr_no_irq_yet", 64'(irq_pulse), 64'd0);
    tick();
    chk("thr_irq", 64'(irq_pulse), 64'd1);
    chk("thr_done0", 64'(done_cnt), 64'd0);
    tick();
    chk("thr_irq_one_cycle", 64'(irq_pulse), 64'd0);

    // Timeout: no completions -> no interrupt; one completion -> a+101 (+-1).
    irq_thr = '0; irq_tmo = 16'd100;
    irq_seen = 0;
    repeat (150) begin tick(); if (irq_pulse) irq_seen++; end
    chk("tmo_no_completion", 64'(irq_seen), 64'd0);
    epoch_pulse = 16'h0040; tick(); epoch_pulse = '0;
    tick();
    rd_if.rd_ack = 1'b1; a = cyc; tick(); rd_if.rd_ack = 1'b0;
    irq_at = -1;
    for (int i = 0; i < 200 && irq_at < 0; i++) begin
      tick();
      if (irq_pulse) irq_at = cyc;
    end
    chk("tmo_irq_seen", 64'(irq_at >= 0), 64'd1);
    chk("tmo_irq_window", 64'((irq_at - a) >= 100 && (irq_at - a) <= 102), 64'd1);
    tick();

    // Ack coincident with the threshold compare.
    irq_tmo = '0; irq_thr = 16'd2;
    epoch_pulse = 16'h0007; tick(); epoch_pulse = '0;
    rd_if.rd_ack = 1'b1;
    repeat (4) tick();
    rd_if.rd_ack = 1'b0;
    chk("coinc_irq", 64'(irq_pulse), 64'd1);
    chk("coinc_done1", 64'(done_cnt), 64'd1);
    tick();

    // Disabled channel never granted.
    ch_en = 16'hFF7F;
    epoch_pulse = 16'h0080; tick(); epoch_pulse = '0;
    repeat (4) tick();
    chk("en_no_req", 64'(rd_if.rd_req), 64'd0);
    chk("en_not_busy", 64'(busy), 64'd0);
    ch_en = '1;

    // Asynchronous reset mid-request.
    epoch_pulse = 16'h0010; tick(); epoch_pulse = '0;
    tick();
    chk("rst_pre_req", 64'(rd_if.rd_req), 64'd1);
    #2 resetn = 1'b0;
    #1 chk_reset_values("async_rst");
    model_reset();
    @(posedge clk); #1;
    chk_reset_values("held_rst");
    resetn = 1'b1;

    // Randomized traffic against the reference.
    irq_thr = 16'd5; irq_tmo = 16'd20;
    for (int n = 0; n < 2000; n++) begin
      epoch_pulse = N_CH'($urandom & $urandom & $urandom);
      ch_en = ~N_CH'($urandom & $urandom & $urandom & $urandom);
      rd_if.rd_ack = 1'($urandom_range(0, 1));
      ovr_clr = ($urandom_range(0, 15) == 0) ? N_CH'($urandom) : '0;
      if ($urandom_range(0, 199) == 0) irq_thr = CNT_W'($urandom_range(0, 8));
      if ($urandom_range(0, 199) == 0) irq_tmo = CNT_W'($urandom_range(0, 30));
      tick();
    end
    epoch_pulse = '0; ovr_clr = '0; rd_if.rd_ack = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/corr_epoch_sched.md
# corr_epoch_sched

Round-robin readout scheduler for a bank of correlator channels. Each channel asserts a one-cycle epoch pulse when it latches a fresh IQ set. The block records these as pending requests and grants them one at a time to a single shared readout mover through a req/ack handshake. It counts completed readouts, raises a coalesced interrupt pulse on a count threshold or timeout, and flags per-channel overruns.

## Interface
- N_CH, 16, number of correlator channels (2..64)
- CH_W, $clog2(N_CH), channel index width
- CNT_W, 16, width of coalescing count and timeout counters
- clk  in  1  ADC-domain clock (same clock as correlator accumulators)
- resetn  in  1  asynchronous, active-low reset
- epoch_pulse  in  N_CH  one-cycle pulse per channel: new IQ latched
- ch_en  in  N_CH  channel enable; disabled channels never become pending
- rd_req  out  1  request to readout mover, registered
- rd_ch  out  CH_W  channel index of current request, stable while rd_req=1
- rd_ack  in  1  mover has copied rd_ch's IQ; valid only while rd_req=1
- irq_thr  in  CNT_W  completions per interrupt; 0 disables threshold trigger
- irq_tmo  in  CNT_W  clk cycles after first unreported completion; 0 disables timeout trigger
- irq_pulse  out  1  one-cycle coalesced interrupt
- done_cnt  out  CNT_W  completions since last irq_pulse
- overrun  out  N_CH  sticky per-channel overrun flags
- ovr_clr  in  N_CH  one-cycle clear of matching overrun bits
- busy  out  1  rd_req=1 or any pending bit set

## Operation
- Reset values: pending=0, rd_req=0, rd_ch=0, last grant=N_CH-1, irq_pulse=0, done_cnt=0, timer=0, overrun=0, busy=0.
- Pending set: epoch_pulse[i] & ch_en[i] sets pending[i]. Clearing ch_en[i] clears pending[i] the next cycle. An in-flight request is not aborted.
- Overrun[i] is set by epoch_pulse[i] & ch_en[i] in either of these cases:
  - pending[i] is already 1 (pending stays 1);
  - rd_req=1 and rd_ch=i and rd_ack=0 (pending[i] is set again).
  - ovr_clr[i] in the same cycle as a set: the set wins.
- FSM has two states:
  - IDLE: if any pending bit is set, choose the first pending index searching upward from last+1, modulo N_CH. Register rd_ch, clear that pending bit, set rd_req, go to REQ.
  - REQ: hold rd_req and rd_ch. On rd_ack: update last=rd_ch and increment done_cnt. If other pending bits are set, grant the next one in the same cycle (rd_req stays 1, rd_ch changes). Otherwise drop rd_req and return to IDLE.
- Coalescing:
  - The timer runs while done_cnt>0 and increments each cycle.
  - irq_pulse fires when (irq_thr≠0 and done_cnt reaches irq_thr) or (irq_tmo≠0 and timer reaches irq_tmo).
  - On irq_pulse: timer=0. done_cnt=1 if rd_ack arrives in the same cycle, else 0.
  - done_cnt saturates at 2^CNT_W-1.
- Changing irq_thr or irq_tmo takes effect on the next compare. A value at or below the current count fires on the next cycle.

## Timing
- epoch_pulse at cycle t sets pending at t+1. If IDLE, rd_req=1 at t+2.
- Back-to-back grants: rd_ack at cycle a gives the next rd_ch at a+1 with no gap. Throughput is one readout per cycle when the mover acks immediately.
- rd_ack is ignored when rd_req=0.
- irq_pulse is registered: the compare condition true at cycle c drives irq_pulse=1 at c+1, for exactly one cycle.
- busy updates one cycle after pending or rd_req changes.
- resetn assertion mid-request drops rd_req immediately (asynchronously) and discards all pending state. The mover must tolerate an abandoned request.

## Test plan
- Single channel: epoch_pulse[3] at t=10 with mover ack 4 cycles later -> rd_req=1, rd_ch=3 at t=12; rd_req=0 at t=17; done_cnt=1.
- Round robin: channels 1, 5, 9 pulse in the same cycle, last=5, immediate ack -> grant order 9, 1, 5 on consecutive cycles.
- Overrun:
  - Case 1: epoch_pulse[2] twice while mover is stalled and channel 2 is pending -> overrun[2]=1, one grant only.
  - Case 2: pulse during its own REQ -> overrun[2]=1 and a second grant after the ack.
  - ovr_clr[2] -> overrun[2]=0.
- Threshold: irq_thr=4, irq_tmo=0, 4 readouts -> irq_pulse one cycle after 4th ack; done_cnt returns to 0. Ack coincident with irq -> done_cnt=1.
- Timeout: irq_thr=0, irq_tmo=100, one readout acked at cycle a -> irq_pulse at a+101 (±1 per the registered compare); no irq if no completions.
- Reset/enable: ch_en[7]=0 and epoch_pulse[7] -> never granted. resetn low during REQ -> rd_req=0, all outputs at reset values.
